// File: rtl/mic_frame_store_if.sv
// Bundle of the sample-capture, configuration and frame-read signals of mic_frame_store.
// The front-end/controller side uses the master modport, the store uses the slave modport.
interface mic_frame_store_if #(
    parameter int DW  = 18,
    parameter int NCH = 2,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH-1:0]    new_t;
    logic [NCH*DW-1:0] t;
    logic [3:0]        sel_addr_wth;
    logic              rd_start;
    logic [CHW-1:0]    rd_ch;
    logic              busy;
    logic [DW-1:0]     q;
    logic              q_valid;
    logic              q_last;
    logic              underfill;
    logic [NCH-1:0]    overflow;

    modport master (
        output new_t, t, sel_addr_wth, rd_start, rd_ch,
        input  busy, q, q_valid, q_last, underfill, overflow
    );

    modport slave (
        input  new_t, t, sel_addr_wth, rd_start, rd_ch,
        output busy, q, q_valid, q_last, underfill, overflow
    );
endinterface

// File: rtl/mic_frame_store.sv
// Multi-channel circular sample store: per-channel strobe capture into a shared single-port
// RAM, and a framed oldest-first readout of the last 2^N samples of one channel.
module mic_frame_store #(
    parameter int DW  = 18,
    parameter int MAW = 10,
    parameter int NCH = 2,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    mic_frame_store_if.slave bus
);
    localparam int         AW    = CHW + MAW;
    localparam logic [3:0] MAW_N = 4'(MAW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [MAW-1:0]  raddr_q, raddr_d;
    logic [MAW-1:0]  cnt_q, cnt_d;
    logic            underfill_q, underfill_d;
    logic            busy_q;
    logic            q_valid_q;
    logic            q_last_q;
    logic [DW-1:0]   q_q;
    logic [3:0]      neff_q;

    logic [NCH-1:0]  sync1_q, sync2_q;
    logic [NCH-1:0]  full_q;
    logic [NCH-1:0]  overflow_q;
    logic [DW-1:0]   hold_q [NCH];
    logic [MAW-1:0]  head_q [NCH];
    logic [MAW:0]    fill_q [NCH];
    logic [DW-1:0]   mem_q  [0:(2**AW)-1];

    logic [3:0]      neff_in_s;
    logic [MAW:0]    len_s;
    logic [MAW:0]    len_m1_s;
    logic [MAW-1:0]  mask_s;
    logic [NCH-1:0]  edge_s;
    logic            flush_s;
    logic            rd_accept_s;
    logic            wr_any_s;
    logic            wr_go_s;
    logic [CHW-1:0]  wr_ch_s;
    logic [NCH-1:0]  wr_hit_s;
    logic [AW-1:0]   ram_addr_s;

    assign neff_in_s   = ((bus.sel_addr_wth == 4'd0) || (bus.sel_addr_wth > MAW_N)) ?
                         MAW_N : bus.sel_addr_wth;
    assign len_s       = {{MAW{1'b0}}, 1'b1} << neff_q;
    assign len_m1_s    = len_s - {{MAW{1'b0}}, 1'b1};
    assign mask_s      = len_m1_s[MAW-1:0];
    assign edge_s      = sync1_q & ~sync2_q;
    // A frame-length change only takes effect between reads; that cycle belongs to the flush.
    assign flush_s     = (state_q == IDLE) && (neff_in_s != neff_q);
    assign rd_accept_s = (state_q == IDLE) && bus.rd_start && !flush_s;
    assign wr_go_s     = wr_any_s && (state_q == IDLE) && !rd_accept_s && !flush_s;
    assign ram_addr_s  = (state_q == READ) ? {ch_q, raddr_q} : {wr_ch_s, head_q[wr_ch_s]};

    // Write arbitration: lowest-index channel with a pending holding register wins.
    always_comb begin
        wr_any_s = 1'b0;
        wr_ch_s  = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (full_q[c]) begin
                wr_any_s = 1'b1;
                wr_ch_s  = CHW'(c);
            end else begin
                wr_any_s = wr_any_s;
            end
        end
    end

    // Per-channel decode of the granted write.
    always_comb begin
        wr_hit_s = '0;
        for (int c = 0; c < NCH; c++) begin
            wr_hit_s[c] = wr_go_s && (wr_ch_s == CHW'(c));
        end
    end

    // Read sequencer next-state logic.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        raddr_d     = raddr_q;
        cnt_d       = cnt_q;
        underfill_d = underfill_q;
        case (state_q)
            IDLE: begin
                if (rd_accept_s) begin
                    state_d     = READ;
                    ch_d        = bus.rd_ch;
                    raddr_d     = head_q[bus.rd_ch];
                    cnt_d       = '0;
                    underfill_d = (fill_q[bus.rd_ch] < len_s);
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                raddr_d = (raddr_q + MAW'(1)) & mask_s;
                cnt_d   = cnt_q + MAW'(1);
                if (cnt_q == mask_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = READ;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, frame framing flags and the active frame length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            raddr_q     <= '0;
            cnt_q       <= '0;
            underfill_q <= 1'b0;
            busy_q      <= 1'b0;
            q_valid_q   <= 1'b0;
            q_last_q    <= 1'b0;
            neff_q      <= neff_in_s;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            raddr_q     <= raddr_d;
            cnt_q       <= cnt_d;
            underfill_q <= underfill_d;
            busy_q      <= (state_d != IDLE);
            q_valid_q   <= (state_q == READ);
            q_last_q    <= (state_q == READ) && (cnt_q == mask_s);
            if (flush_s) begin
                neff_q <= neff_in_s;
            end
        end
    end

    // Strobe edge detection, holding registers, ring heads and fill tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            full_q     <= '0;
            overflow_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                hold_q[c] <= '0;
                head_q[c] <= '0;
                fill_q[c] <= '0;
            end
        end else begin
            sync1_q <= bus.new_t;
            sync2_q <= sync1_q;
            for (int c = 0; c < NCH; c++) begin
                overflow_q[c] <= edge_s[c] && full_q[c] && !wr_hit_s[c];
                if (edge_s[c]) begin
                    hold_q[c] <= bus.t[c*DW +: DW];
                    full_q[c] <= 1'b1;
                end else if (wr_hit_s[c]) begin
                    full_q[c] <= 1'b0;
                end
                if (flush_s) begin
                    head_q[c] <= '0;
                    fill_q[c] <= '0;
                end else if (wr_hit_s[c]) begin
                    head_q[c] <= (head_q[c] + MAW'(1)) & mask_s;
                    if (fill_q[c] < len_s) begin
                        fill_q[c] <= fill_q[c] + (MAW+1)'(1);
                    end
                end
            end
        end
    end

    // Sample RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_go_s) begin
            mem_q[ram_addr_s] <= hold_q[wr_ch_s];
        end
    end

    // Registered RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (state_q == READ) begin
            q_q <= mem_q[ram_addr_s];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.q         = q_q;
    assign bus.q_valid   = q_valid_q;
    assign bus.q_last    = q_last_q;
    assign bus.underfill = underfill_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_mic_frame_store.sv
// Directed bench for mic_frame_store: frame-length table plus hand sequences for
// reset, fill/read, underfill, write contention, overflow and reconfiguration.
module tb_mic_frame_store;
    localparam int DW  = 18;
    localparam int MAW = 10;
    localparam int NCH = 2;
    localparam int CHW = 1;

    typedef struct {
        logic [3:0] sel;
        int         n_wr;
        int         exp_len;
        int         exp_uf;
        int         exp_last_q;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mic_frame_store_if #(.DW(DW), .NCH(NCH), .CHW(CHW)) bus ();

    mic_frame_store #(.DW(DW), .MAW(MAW), .NCH(NCH), .CHW(CHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   got_q [1024];
    int   got_len;
    int   last_idx;
    int   first_iter;
    int   got_uf;
    int   ovf0 = 0;
    int   ovf1 = 0;
    vec_t vecs [5];

    // Count overflow pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            ovf0 <= ovf0 + int'(bus.overflow[0]);
            ovf1 <= ovf1 + int'(bus.overflow[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input int ch, input int val);
        bus.t[ch*DW +: DW] = DW'(val);
        bus.new_t[ch]      = 1'b1;
        tick();
        tick();
        bus.new_t[ch]      = 1'b0;
        repeat (3) tick();
    endtask

    task automatic read_frame(input int ch);
        int done;
        done       = 0;
        got_len    = 0;
        last_idx   = -1;
        first_iter = -1;
        bus.rd_ch    = CHW'(ch);
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        for (int i = 1; i <= 1200 && done == 0; i++) begin
            tick();
            if (bus.q_valid) begin
                if (got_len == 0) first_iter = i;
                if (bus.q_last && last_idx < 0) last_idx = got_len;
                if (got_len < 1024) got_q[got_len] = int'(bus.q);
                got_len++;
            end
            if (!bus.busy) done = 1;
        end
        got_uf = int'(bus.underfill);
        check("read_done", done, 1);
    endtask

    initial begin
        vecs[0] = '{4'd1,  3, 2,    0, 502};
        vecs[1] = '{4'd0,  0, 1024, 1, 0};
        vecs[2] = '{4'd12, 0, 1024, 1, 0};
        vecs[3] = '{4'd4,  2, 16,   1, 501};
        vecs[4] = '{4'd10, 0, 1024, 1, 0};

        bus.new_t        = '0;
        bus.t            = '0;
        bus.sel_addr_wth = 4'd3;
        bus.rd_start     = 1'b0;
        bus.rd_ch        = '0;

        // Reset held with strobes toggling.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.new_t = ~bus.new_t;
            tick();
        end
        bus.new_t = '0;
        check("rst_busy",      int'(bus.busy),      0);
        check("rst_q_valid",   int'(bus.q_valid),   0);
        check("rst_q_last",    int'(bus.q_last),    0);
        check("rst_underfill", int'(bus.underfill), 0);
        check("rst_overflow",  int'(bus.overflow),  0);
        check("rst_q",         int'(bus.q),         0);
        rst = 1'b0;
        repeat (2) tick();

        // N=3, ch0 samples 1..10: frame is 3..10.
        for (int k = 1; k <= 10; k++) strobe(0, k);
        read_frame(0);
        check("fill_len",   got_len,    8);
        check("fill_first", first_iter, 1);
        check("fill_last",  last_idx,   7);
        check("fill_uf",    got_uf,     0);
        for (int k = 0; k < 8; k++) check($sformatf("fill_q%0d", k), got_q[k], 3 + k);

        // N=2 flush, ch1 holds only 2 samples.
        bus.sel_addr_wth = 4'd2;
        repeat (2) tick();
        strobe(1, 5);
        strobe(1, 6);
        read_frame(1);
        check("uf_len",  got_len,  4);
        check("uf_flag", got_uf,   1);
        check("uf_q2",   got_q[2], 5);
        check("uf_q3",   got_q[3], 6);
        tick();
        check("uf_sticky", int'(bus.underfill), 1);
        strobe(1, 7);
        strobe(1, 8);
        read_frame(1);
        check("uf_clr", got_uf, 0);
        for (int k = 0; k < 4; k++) check($sformatf("uf_full_q%0d", k), got_q[k], 5 + k);

        // Simultaneous strobes: ch0 written first, a read then blocks ch1's write.
        bus.t[0*DW +: DW] = DW'(100);
        bus.t[1*DW +: DW] = DW'(200);
        bus.new_t = 2'b11;
        tick();
        tick();
        bus.new_t = 2'b00;
        tick();
        read_frame(1);
        check("cont_ch1_pre_q0", got_q[0], 5);
        check("cont_ch1_pre_q3", got_q[3], 8);
        repeat (2) tick();
        read_frame(0);
        check("cont_ch0_q0",   got_q[0], 10);
        check("cont_ch0_last", got_q[3], 100);
        check("cont_ch0_uf",   got_uf,   1);
        read_frame(1);
        check("cont_ch1_q0",   got_q[0], 6);
        check("cont_ch1_last", got_q[3], 200);
        check("cont_ovf",      ovf0 + ovf1, 0);

        // N=4, two ch1 strobes during a ch0 read.
        bus.sel_addr_wth = 4'd4;
        repeat (2) tick();
        fork
            read_frame(0);
            begin
                repeat (2) tick();
                strobe(1, 300);
                strobe(1, 301);
            end
        join
        check("ovf_len", got_len, 16);
        check("ovf_ch1", ovf1, 1);
        check("ovf_ch0", ovf0, 0);
        repeat (3) tick();
        read_frame(1);
        check("ovf_ch1_last", got_q[15], 301);
        check("ovf_ch1_uf",   got_uf,    1);
        check("ovf_ch1_once", ovf1,      1);

        // N=2 wrap, then reconfigure with a read request in the flush cycle.
        bus.sel_addr_wth = 4'd2;
        repeat (2) tick();
        for (int k = 0; k <= 6; k++) strobe(0, k);
        read_frame(0);
        check("wrap_uf", got_uf, 0);
        for (int k = 0; k < 4; k++) check($sformatf("wrap_q%0d", k), got_q[k], 3 + k);
        bus.sel_addr_wth = 4'd5;
        bus.rd_ch        = 1'b0;
        bus.rd_start     = 1'b1;
        tick();
        bus.rd_start     = 1'b0;
        check("flush_busy0", int'(bus.busy), 0);
        tick();
        check("flush_busy1", int'(bus.busy), 0);
        read_frame(0);
        check("flush_len", got_len, 32);
        check("flush_uf",  got_uf,  1);

        // Frame-length clamp table.
        for (int v = 0; v < 5; v++) begin
            bus.sel_addr_wth = vecs[v].sel;
            repeat (2) tick();
            for (int k = 0; k < vecs[v].n_wr; k++) strobe(0, 500 + k);
            read_frame(0);
            check($sformatf("tbl%0d_len", v),  got_len,  vecs[v].exp_len);
            check($sformatf("tbl%0d_last", v), last_idx, vecs[v].exp_len - 1);
            check($sformatf("tbl%0d_uf", v),   got_uf,   vecs[v].exp_uf);
            if (vecs[v].n_wr > 0) begin
                check($sformatf("tbl%0d_lastq", v), got_q[vecs[v].exp_len - 1], vecs[v].exp_last_q);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mic_frame_store.md
Name: mic_frame_store

Overview:
- Multi-channel circular sample store between the microphone front-end and the FFT.
- Captures one sample per channel on each rising edge of that channel's strobe, into a shared single-port RAM partitioned per channel.
- On request, streams the most recent 2^N samples of one selected channel, oldest first, with valid/last framing.
- Generalises the single-channel store with parametrised width, depth and channel count, per-channel holding buffers with overflow reporting, fill tracking and a framed read stream.

Parameters:
DW, 18, sample width in bits
MAW, 10, max per-channel address width (max frame 2^MAW samples)
NCH, 2, number of microphone channels (1..8)
CHW, $clog2(NCH) (min 1), channel index width

Ports:
clk  in  1  system clock
rst  in  1  reset
new_t  in  NCH  per-channel sample strobe (level, rising edge = new sample; may be asynchronous)
t  in  NCH*DW  per-channel sample data, channel c at [c*DW +: DW], stable while new_t[c] high
sel_addr_wth  in  4  frame length exponent N; 0 or >MAW clamps to MAW
rd_start  in  1  one-cycle frame read request
rd_ch  in  CHW  channel to read, sampled with rd_start
busy  out  1  read in progress
q  out  DW  read sample
q_valid  out  1  q holds a frame sample
q_last  out  1  with q_valid, final sample of the frame
underfill  out  1  sticky: frame read issued before the channel held L samples; cleared on next accepted rd_start
overflow  out  NCH  one-cycle pulse: channel's holding register overwritten before its sample was written

Behaviour:
- Reset is synchronous, active-high, on clk. It clears all outputs to 0, all heads/fill counters/holding flags to 0, state to IDLE and edge-detect flops to 0. RAM contents are not cleared.
- Reset asserted mid-read aborts the frame. No q_last is produced.
- Edge detect: two flops per channel. The edge is d1 & ~d2, giving capture 2 cycles after new_t rises.
- On an edge, t[c] is loaded into hold[c] and full[c] is set.
  - If full[c] is already set and the pending sample has not been written in the same cycle: overwrite, overflow[c] = 1 for one cycle.
- Write port: free when state is IDLE and no read is being accepted this cycle.
  - When free, the lowest-index channel with full set is written at address {c, head[c]}.
  - Its full flag is cleared, head[c] increments, and fill[c] saturates at L.
  - One write per cycle.
- L = 2^Neff, where Neff is the clamped sel_addr_wth. head[c] wraps L-1 -> 0.
- Neff is registered. A change of Neff while IDLE causes a flush: all heads and fills go to 0 the next cycle. Pending holds are kept.
- A change of Neff while busy is deferred until IDLE.
- State machine:
  - IDLE: rd_start with no flush pending -> READ. Latch ch = rd_ch, raddr = head[ch], cnt = 0, and set underfill if fill[ch] < L. rd_start while busy or during a flush cycle is ignored.
  - READ: issue address {ch, raddr}. raddr = (raddr+1) mod L, cnt++. At cnt = L-1 -> DRAIN.
  - DRAIN: one cycle for the final RAM read data, then IDLE.
- busy = (state != IDLE).
- RAM read latency is 1 cycle. q_valid goes high the cycle after each issued address, so exactly L consecutive q_valid cycles, the first 2 cycles after rd_start. q_last accompanies the L-th.
- Reads return the oldest-first order starting at head, which is the oldest sample once fill = L.
- Samples arriving during a read wait in hold[]. Their write is deferred to IDLE. A second edge on the same channel during the read causes overflow.
- Read and write never share a cycle.
- Arithmetic: all pointers are MAW bits, masked to Neff bits. fill is MAW+1 bits.

Test Plan:
- Reset: hold rst 3 cycles with new_t toggling -> all outputs 0, no RAM writes, busy 0.
- Single channel fill/read: NCH=2, N=3. Feed ch0 samples 1..10 -> rd_start, rd_ch=0 -> q_valid 8 cycles starting 2 cycles after rd_start, q = 3,4,...,10. q_last on 10. underfill 0.
- Underfill: after flush, N=2, write ch1 samples 5,6 -> read ch1 gives 4 q_valid beats, underfill=1. The next read after 4 samples clears it.
- Contention: strobe ch0 and ch1 on the same cycle -> ch0 written first, ch1 next cycle. Both heads = 1.
- Overflow during read: N=4, start read of ch0, strobe ch1 twice during READ -> overflow[1] pulses once. After DRAIN the second sample is written and head[1] increments by 1.
- Wrap and reconfig: N=2, write ch0 samples 0..6 -> read gives 3,4,5,6. Change sel_addr_wth to 5 -> flush, fill[0]=0, a rd_start in the flush cycle is ignored (busy stays 0).
